// File: rtl/seg_scroll_capture.sv
// Receive side of the nibble-scroll display: samples the 4-digit window each scroll tick,
// rebuilds the 6-nibble circular message, aligns it on the marker and recovers the payload.
module seg_scroll_capture #(
    parameter logic [3:0] MARK   = 4'hC,
    parameter int         RCNT_W = 4
) (
    input  logic              clk_3,
    input  logic              clr,
    input  logic              en,
    input  logic [15:0]       scroll_window,
    output logic [19:0]       data_out,
    output logic              data_valid,
    output logic              frame_stb,
    output logic              locked,
    output logic              ambig,
    output logic [RCNT_W-1:0] resync_cnt
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        FILL   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [RCNT_W-1:0] RCNT_MAX = {RCNT_W{1'b1}};
    localparam logic [RCNT_W-1:0] RCNT_ONE = {{(RCNT_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic [23:0]       ring_r, ring_s;
    logic [2:0]        cnt_r, cnt_s;
    logic [2:0]        vcnt_r, vcnt_s;
    logic [15:0]       prev_r, prev_s;
    logic [19:0]       data_out_r, data_out_s;
    logic              data_valid_r, data_valid_s;
    logic              frame_stb_r, frame_stb_s;
    logic              locked_r, locked_s;
    logic              ambig_r, ambig_s;
    logic [RCNT_W-1:0] resync_r, resync_s;

    logic              consistent_s;
    logic              step_ok_s;
    logic [3:0]        nib_s;
    logic [23:0]       pushed_s;
    logic [23:0]       seeded_s;
    logic [2:0]        mark_cnt_s;
    logic [2:0]        mark_idx_s;
    logic [23:0]       aligned_s;

    function automatic logic [2:0] mark_count(input logic [23:0] r);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (r[4*i +: 4] == MARK) begin
                c = c + 3'd1;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    function automatic logic [2:0] mark_index(input logic [23:0] r);
        logic [2:0] idx;
        idx = 3'd5;
        for (int i = 0; i < 6; i++) begin
            if (r[4*i +: 4] == MARK) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Rotate so that nibble idx ends up in the top nibble position.
    function automatic logic [23:0] rotate_to_top(input logic [23:0] r, input logic [2:0] idx);
        logic [23:0] o;
        case (idx)
            3'd0:    o = {r[3:0],  r[23:4]};
            3'd1:    o = {r[7:0],  r[23:8]};
            3'd2:    o = {r[11:0], r[23:12]};
            3'd3:    o = {r[15:0], r[23:16]};
            3'd4:    o = {r[19:0], r[23:20]};
            default: o = r;
        endcase
        return o;
    endfunction

    // Per-tick datapath: rotation check, ring push/seed and marker alignment of the pushed ring.
    always_comb begin
        nib_s        = scroll_window[15:12];
        consistent_s = (scroll_window[11:0] == prev_r[15:4]);
        step_ok_s    = consistent_s && (nib_s == ring_r[3:0]);
        pushed_s     = {nib_s, ring_r[23:4]};
        seeded_s     = {scroll_window, 8'h00};
        mark_cnt_s   = mark_count(pushed_s);
        mark_idx_s   = mark_index(pushed_s);
        aligned_s    = rotate_to_top(pushed_s, mark_idx_s);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        ring_s       = ring_r;
        cnt_s        = cnt_r;
        vcnt_s       = vcnt_r;
        prev_s       = prev_r;
        data_out_s   = data_out_r;
        data_valid_s = data_valid_r;
        ambig_s      = ambig_r;
        resync_s     = resync_r;
        frame_stb_s  = 1'b0;

        if (en) begin
            prev_s = scroll_window;
            case (state_r)
                SEED: begin
                    ring_s  = seeded_s;
                    cnt_s   = 3'd4;
                    state_s = FILL;
                end
                FILL: begin
                    if (consistent_s) begin
                        ring_s = pushed_s;
                        cnt_s  = cnt_r + 3'd1;
                        if (cnt_r == 3'd5) begin
                            state_s = VERIFY;
                            vcnt_s  = 3'd0;
                        end else begin
                            state_s = FILL;
                        end
                    end else begin
                        ring_s = seeded_s;
                        cnt_s  = 3'd4;
                    end
                end
                VERIFY, LOCKED: begin
                    if (step_ok_s) begin
                        ring_s = pushed_s;
                        if ((state_r == LOCKED) || (vcnt_r == 3'd5)) begin
                            state_s = LOCKED;
                            vcnt_s  = 3'd0;
                            if (mark_cnt_s == 3'd1) begin
                                data_out_s   = aligned_s[19:0];
                                data_valid_s = 1'b1;
                                ambig_s      = 1'b0;
                                frame_stb_s  = ~data_valid_r;
                            end else begin
                                data_valid_s = 1'b0;
                                ambig_s      = 1'b1;
                            end
                        end else begin
                            vcnt_s = vcnt_r + 3'd1;
                        end
                    end else begin
                        // Lock loss only counts once we were actually locked.
                        if (state_r == LOCKED) begin
                            resync_s = (resync_r == RCNT_MAX) ? resync_r : resync_r + RCNT_ONE;
                        end else begin
                            resync_s = resync_r;
                        end
                        data_valid_s = 1'b0;
                        ambig_s      = 1'b0;
                        ring_s       = seeded_s;
                        cnt_s        = 3'd4;
                        vcnt_s       = 3'd0;
                        state_s      = FILL;
                    end
                end
                default: begin
                    state_s      = SEED;
                    ring_s       = 24'h000000;
                    cnt_s        = 3'd0;
                    vcnt_s       = 3'd0;
                    data_valid_s = 1'b0;
                    ambig_s      = 1'b0;
                end
            endcase
        end else begin
            frame_stb_s = 1'b0;
        end

        locked_s = (state_s == LOCKED);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_3 or posedge clr) begin
        if (clr) begin
            state_r      <= SEED;
            ring_r       <= 24'h000000;
            cnt_r        <= 3'd0;
            vcnt_r       <= 3'd0;
            prev_r       <= 16'h0000;
            data_out_r   <= 20'h00000;
            data_valid_r <= 1'b0;
            frame_stb_r  <= 1'b0;
            locked_r     <= 1'b0;
            ambig_r      <= 1'b0;
            resync_r     <= {RCNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            ring_r       <= ring_s;
            cnt_r        <= cnt_s;
            vcnt_r       <= vcnt_s;
            prev_r       <= prev_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            frame_stb_r  <= frame_stb_s;
            locked_r     <= locked_s;
            ambig_r      <= ambig_s;
            resync_r     <= resync_s;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_stb  = frame_stb_r;
    assign locked     = locked_r;
    assign ambig      = ambig_r;
    assign resync_cnt = resync_r;

endmodule

// File: tb/tb_seg_scroll_capture.sv
// Directed bench for seg_scroll_capture: a small rotating-message source drives the window,
// and each step compares the capture outputs against hand-derived values.
module tb_seg_scroll_capture;

    logic        clk_3;
    logic        clr;
    logic        en;
    logic [15:0] scroll_window;
    logic [19:0] data_out;
    logic        data_valid;
    logic        frame_stb;
    logic        locked;
    logic        ambig;
    logic [3:0]  resync_cnt;

    logic [23:0] msg;
    int          tests;
    int          fails;

    seg_scroll_capture #(.MARK(4'hC), .RCNT_W(4)) dut (
        .clk_3         (clk_3),
        .clr           (clr),
        .en            (en),
        .scroll_window (scroll_window),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .frame_stb     (frame_stb),
        .locked        (locked),
        .ambig         (ambig),
        .resync_cnt    (resync_cnt)
    );

    initial clk_3 = 1'b0;
    always #5 clk_3 = ~clk_3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the next source window, take one edge, then rotate the source right one nibble.
    task automatic gen_tick();
        scroll_window = msg[23:8];
        @(posedge clk_3);
        #1;
        msg = {msg[3:0], msg[23:4]};
    endtask

    task automatic expect_lock_after(input int n, input string tag);
        for (int k = 1; k < n; k++) begin
            gen_tick();
            chk({tag, "_unlocked"}, {31'd0, locked}, 32'd0);
        end
        gen_tick();
        chk({tag, "_locked"}, {31'd0, locked}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"},   {12'd0, data_out},   32'd0);
        chk({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
        chk({tag, "_frame_stb"},  {31'd0, frame_stb},  32'd0);
        chk({tag, "_locked"},     {31'd0, locked},     32'd0);
        chk({tag, "_ambig"},      {31'd0, ambig},      32'd0);
        chk({tag, "_resync"},     {28'd0, resync_cnt}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clr   = 1'b1;
        en    = 1'b1;
        msg   = 24'h2345C1;
        scroll_window = 16'h0000;
        #2;
        check_all_zero("reset");
        #1;
        clr = 1'b0;

        // Clean lock on payload 12345: locked on the ninth edge
        expect_lock_after(9, "clean");
        chk("clean_valid",  {31'd0, data_valid}, 32'd1);
        chk("clean_stb",    {31'd0, frame_stb},  32'd1);
        chk("clean_data",   {12'd0, data_out},   32'h12345);
        chk("clean_ambig",  {31'd0, ambig},      32'd0);
        chk("clean_resync", {28'd0, resync_cnt}, 32'd0);

        for (int k = 0; k < 30; k++) begin
            gen_tick();
            chk("steady_stb",    {31'd0, frame_stb}, 32'd0);
            chk("steady_locked", {31'd0, locked},    32'd1);
            chk("steady_data",   {12'd0, data_out},  32'h12345);
        end

        // One corrupted window while locked; the source keeps rotating underneath
        scroll_window = 16'h9999;
        @(posedge clk_3);
        #1;
        msg = {msg[3:0], msg[23:4]};
        chk("glitch_locked", {31'd0, locked},     32'd0);
        chk("glitch_valid",  {31'd0, data_valid}, 32'd0);
        chk("glitch_resync", {28'd0, resync_cnt}, 32'd1);
        chk("glitch_hold",   {12'd0, data_out},   32'h12345);
        chk("glitch_ambig",  {31'd0, ambig},      32'd0);
        expect_lock_after(9, "relock");
        chk("relock_stb",   {31'd0, frame_stb},  32'd1);
        chk("relock_valid", {31'd0, data_valid}, 32'd1);
        chk("relock_data",  {12'd0, data_out},   32'h12345);
        gen_tick();
        chk("relock_stb_once", {31'd0, frame_stb}, 32'd0);

        // Enable low with the source frozen: no change, no resync
        en = 1'b0;
        scroll_window = msg[23:8];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_3);
            #1;
            chk("frozen_locked", {31'd0, locked},    32'd1);
            chk("frozen_stb",    {31'd0, frame_stb}, 32'd0);
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gen_tick();
            chk("resume_locked", {31'd0, locked},     32'd1);
            chk("resume_resync", {28'd0, resync_cnt}, 32'd1);
            chk("resume_data",   {12'd0, data_out},   32'h12345);
        end

        // Asynchronous clear between edges
        #2;
        clr = 1'b1;
        #1;
        check_all_zero("aclr");
        #1;
        clr = 1'b0;
        expect_lock_after(9, "aclr_relock");
        chk("aclr_valid",  {31'd0, data_valid}, 32'd1);
        chk("aclr_stb",    {31'd0, frame_stb},  32'd1);
        chk("aclr_data",   {12'd0, data_out},   32'h12345);
        chk("aclr_resync", {28'd0, resync_cnt}, 32'd0);

        // Enable low for 5 ticks during VERIFY while the source keeps rotating
        #2;
        clr = 1'b1;
        #2;
        clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            gen_tick();
            chk("pre_hold_unlocked", {31'd0, locked}, 32'd0);
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            gen_tick();
            chk("hold_unlocked", {31'd0, locked}, 32'd0);
        end
        en = 1'b1;
        expect_lock_after(9, "hold_relock");
        chk("hold_valid",  {31'd0, data_valid}, 32'd1);
        chk("hold_data",   {12'd0, data_out},   32'h12345);
        chk("hold_resync", {28'd0, resync_cnt}, 32'd0);

        // Payload 1C345 carries a second marker nibble
        #2;
        clr = 1'b1;
        #2;
        clr = 1'b0;
        msg = 24'hC1C345;
        for (int k = 1; k < 9; k++) begin
            gen_tick();
            chk("amb_unlocked", {31'd0, locked},    32'd0);
            chk("amb_stb_pre",  {31'd0, frame_stb}, 32'd0);
        end
        gen_tick();
        chk("amb_locked", {31'd0, locked},     32'd1);
        chk("amb_ambig",  {31'd0, ambig},      32'd1);
        chk("amb_valid",  {31'd0, data_valid}, 32'd0);
        chk("amb_data",   {12'd0, data_out},   32'd0);
        chk("amb_stb",    {31'd0, frame_stb},  32'd0);
        gen_tick();
        chk("amb_hold_ambig", {31'd0, ambig},     32'd1);
        chk("amb_hold_stb",   {31'd0, frame_stb}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scroll_capture.md
Name: seg_scroll_capture

Overview:
- Receive-side counterpart of the 3 Hz nibble-scroll generator.
- Samples the 16-bit, 4-digit scrolling display window on every scroll tick and checks that it rotates consistently.
- Rebuilds the full 6-nibble circular message, aligns it on the marker nibble and recovers the original 20-bit payload.
- Sits between the scroll generator output and self-check/readback logic (board loopback, status LED, verification).

Parameters:
- MARK, 4'hC, separator nibble inserted by the scroll generator at message top.
- RCNT_W, 4, width of the saturating resync counter.

Ports:
- clk_3  input  1  scroll clock, rising edge; same clock that advances the scroll generator.
- clr  input  1  reset, asynchronous, active-high.
- en  input  1  sample enable; low = hold all state, no checks performed.
- scroll_window  input  16  current 4-nibble display window from the generator.
- data_out  output  20  recovered payload, message nibbles following MARK.
- data_valid  output  1  high while locked and exactly one MARK exists in the ring.
- frame_stb  output  1  one-clk_3 pulse when data_valid rises.
- locked  output  1  high in LOCKED state.
- ambig  output  1  high while locked and MARK count in ring != 1.
- resync_cnt  output  RCNT_W  saturating count of lock losses.

Behaviour:
- Reset (clr=1, async): state=SEED, ring=0, cnt=0, vcnt=0, prev=0. Outputs: data_out=0, data_valid=0, frame_stb=0, locked=0, ambig=0, resync_cnt=0.
- Window rotation rule: the generator rotates right one nibble per tick. A step is consistent iff scroll_window[11:0]==prev[15:4]. The only new nibble is N=scroll_window[15:12].
- All actions below occur on a clk_3 rising edge with en=1. prev<=scroll_window on every enabled edge.
- Seed action: ring<={scroll_window,8'h0}, cnt<=4.
- Push action: ring<={N,ring[23:4]}. The ring then always equals a rotation of the source message register.
- SEED: perform seed action -> FILL.
- FILL:
  - Consistent: push, cnt++. If cnt becomes 6 -> VERIFY with vcnt=0.
  - Inconsistent: seed action, stay in FILL.
- VERIFY:
  - Step passes iff consistent AND N==ring[3:0] (the nibble six steps back). Pass: push, vcnt++.
  - On the 6th pass -> LOCKED. Load data_out, set data_valid/ambig per the marker rule, frame_stb=1 if valid.
  - Any fail: seed action -> FILL, vcnt=0.
- LOCKED:
  - Same per-step check as VERIFY. Pass: push; data_out, data_valid and ambig are recomputed and are stable for a static message.
  - Fail: locked=0, data_valid=0, ambig=0, data_out holds its last value, resync_cnt++ (saturating at all-ones), seed action -> FILL.
- Marker rule:
  - Count MARK nibbles across the 6 ring nibbles.
  - Exactly one: rotate the ring so MARK is in bits [23:20]; data_out=rotated[19:0]; data_valid=1; ambig=0.
  - Otherwise: data_valid=0, ambig=1, data_out holds.
- frame_stb: asserted for exactly one clk_3 after the edge on which data_valid goes 0->1. It is never high for two consecutive cycles.
- en=0: no state change, prev not updated, frame_stb=0. A static window while en=1 is checked normally.
- Latency: from the first enabled edge after clr release, a clean source gives locked=1 and data_valid=1 after edge 9 (1 seed + 2 fill + 6 verify).
- Sampling: scroll_window is registered generator output, so capture sees the pre-edge value. A one-tick phase offset is inherent and harmless.
- clr mid-operation: immediate return to the reset values; resync_cnt is also cleared.

Test Plan:
- Clean lock: source loaded with payload 20'h12345. Windows 0x2345,0x1234,0xC123,0x5C12,0x45C1,0x345C,0x2345,... -> locked=1, data_valid=1 after edge 9, data_out=20'h12345, frame_stb single pulse, resync_cnt=0.
- Steady state: continue 30 further ticks -> data_out stays 20'h12345, no further frame_stb, locked stays 1.
- Glitch: while locked, force one window to 0x9999, then resume the clean sequence -> locked/data_valid drop on that edge, resync_cnt=1, data_out held at 20'h12345, relock within 10 edges, second frame_stb.
- Ambiguous marker: payload 20'h1C345 -> locked=1 after edge 9, ambig=1, data_valid=0, data_out=0, no frame_stb.
- Enable/hold: en=0 for 5 ticks during VERIFY while the source keeps rotating -> on en=1 the first step fails consistency, FILL reseeds, lock follows after 9 enabled edges; with en=0 and the source also frozen, lock resumes with no resync.
- Async reset: clr pulse mid-LOCKED (not aligned to clk_3) -> all outputs 0 immediately including resync_cnt; relock after 9 edges.
